// File: rtl/spi_xfer_ctrl.sv
// Byte-stream front end for spi_core: TX/RX FIFOs plus a per-byte launch/capture FSM; rd_data is show-ahead (0 when empty).
// Launch 2 cycles after a write into an idle controller; TX full drops writes (sticky tx_ovf), RX full stalls launches.
module spi_xfer_ctrl #(
    parameter int DEPTH   = 4,
    parameter int D_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               tx_full,
    output logic               tx_empty,
    output logic               rx_full,
    output logic               rx_empty,
    output logic               tx_ovf,
    input  logic               clr_err,
    output logic               active,
    output logic               spi_enable,
    output logic [D_WIDTH-1:0] spi_tx_data,
    input  logic               spi_busy,
    input  logic [D_WIDTH-1:0] spi_rx_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE
    } state_t;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic [D_WIDTH-1:0] rx_hold;
    logic               launch;

    logic [D_WIDTH-1:0] tx_mem [DEPTH];
    logic [AW-1:0]      tx_wptr, tx_rptr;
    logic [AW:0]        tx_cnt;
    logic               tx_push, tx_pop;

    logic [D_WIDTH-1:0] rx_mem [DEPTH];
    logic [AW-1:0]      rx_wptr, rx_rptr;
    logic [AW:0]        rx_cnt;
    logic               rx_push, rx_pop;

    assign tx_full  = (tx_cnt == (AW+1)'(DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == (AW+1)'(DEPTH));
    assign rx_empty = (rx_cnt == '0);

    // Launch only with a free RX slot; one byte in flight at a time, so RX can never overflow.
    assign launch  = (state == IDLE) && !tx_empty && !rx_full;
    assign tx_push = wr_en && !tx_full;
    assign tx_pop  = launch;
    assign rx_push = (state == CAPTURE);
    assign rx_pop  = rd_en && !rx_empty;
    assign rd_data = rx_empty ? '0 : rx_mem[rx_rptr];
    assign active  = (state != IDLE);

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wptr] <= wr_data;
        if (rx_push) rx_mem[rx_wptr] <= rx_hold;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
        end
    end

    // A write against a full FIFO flags overflow even if a pop frees space on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n)                tx_ovf <= 1'b0;
        else if (wr_en && tx_full)   tx_ovf <= 1'b1;
        else if (clr_err)            tx_ovf <= 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            spi_enable  <= 1'b0;
            spi_tx_data <= '0;
            wait_cnt    <= '0;
            rx_hold     <= '0;
        end else begin
            spi_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state       <= START;
                        spi_enable  <= 1'b1;
                        spi_tx_data <= tx_mem[tx_rptr];
                    end
                end
                START: begin
                    state    <= WAIT_BUSY;
                    wait_cnt <= '0;
                end
                WAIT_BUSY: begin
                    // Give up after 16 cycles without busy; the byte is dropped.
                    if (spi_busy)               state    <= WAIT_DONE;
                    else if (wait_cnt == 4'd15) state    <= IDLE;
                    else                        wait_cnt <= wait_cnt + 4'd1;
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        state   <= CAPTURE;
                        rx_hold <= spi_rx_data;
                    end
                end
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
